// File: rtl/mmm_pkg.sv
// Shared types for the matrix-multiply sequencer and the input memories:
// FSM state encoding and address-width helpers.
package mmm_pkg;

  typedef enum logic [2:0] {IDLE, RUN, HOLD, DRAIN, DONE} state_t;

  // $clog2 that never returns 0, so 1-entry ranges still get a 1-bit counter.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int a_addr_w(input int m, input int maxk);
    return clog2_min1(m * maxk);
  endfunction

  function automatic int b_addr_w(input int maxk, input int n);
    return clog2_min1(maxk * n);
  endfunction

endpackage

// File: rtl/mmm_delay_line.sv
// Reset-clearable shift register; DEPTH=0 degenerates to a wire.
// occupied flags any set bit still in flight.
module mmm_delay_line #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         occupied
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign dout     = din;
      assign occupied = 1'b0;
    end else begin : g_pipe
      logic [DEPTH-1:0][W-1:0] pipe;

      always_ff @(posedge clk) begin
        if (reset) begin
          pipe <= '0;
        end else begin
          pipe[0] <= din;
          for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign dout     = pipe[DEPTH-1];
      assign occupied = |pipe;
    end
  endgenerate

endmodule

// File: rtl/mmm_sequencer.sv
// Matrix-multiply control sequencer: walks C = A*B row-major, issues reads, MAC strobes
// and FIFO writes under a credit scheme. MMM_SEQ_PERF_EN adds stall/job cycle counters.
module mmm_sequencer
  import mmm_pkg::*;
#(
  parameter int M          = 7,
  parameter int N          = 9,
  parameter int MAXK       = 8,
  parameter int RD_LAT     = 1,
  parameter int MAC_LAT    = 1,
  parameter int FIFO_DEPTH = N,
  localparam int KW = $clog2(MAXK + 1),
  localparam int AW = a_addr_w(M, MAXK),
  localparam int BW = b_addr_w(MAXK, N),
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          matrices_loaded,
  input  logic [KW-1:0] K,
  output logic [AW-1:0] a_addr,
  output logic [BW-1:0] b_addr,
  output logic          valid_input,
  output logic          clear_acc,
  output logic          fifo_wr_en,
  input  logic [CW-1:0] fifo_capacity,
  output logic          compute_finished,
  output logic          busy
`ifdef MMM_SEQ_PERF_EN
  ,
  output logic [31:0]   stall_cycles,
  output logic [31:0]   job_cycles
`endif
);

  localparam int RW  = clog2_min1(M);
  localparam int CLW = clog2_min1(N);

  state_t         state;
  logic [KW-1:0]  k_q;
  logic [RW-1:0]  row;
  logic [CLW-1:0] col;
  logic [KW-1:0]  idx;
  logic [AW-1:0]  a_base, a_ptr;
  logic [BW-1:0]  b_ptr;
  logic [CW-1:0]  inflight;
  logic           issue, first, last;
  logic [1:0]     vld_out;
  logic           vld_occ, wr_occ;

  logic [KW-1:0] k_in;
  logic          credit_ok, issue_now, last_idx, last_col, last_row, job_start;

  assign k_in      = (K > KW'(MAXK)) ? KW'(MAXK) : K;
  assign credit_ok = fifo_capacity > inflight;
  // A started dot product always runs to completion; credit only gates idx 0.
  assign issue_now = (state == RUN || state == HOLD) && (idx != '0 || credit_ok);
  assign last_idx  = idx == k_q - KW'(1);
  assign last_col  = col == CLW'(N - 1);
  assign last_row  = row == RW'(M - 1);
  // compute_finished is still high in the cycle after DONE; that cycle ignores the level.
  assign job_start = state == IDLE && matrices_loaded && !compute_finished;

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      k_q              <= '0;
      row              <= '0;
      col              <= '0;
      idx              <= '0;
      a_base           <= '0;
      a_ptr            <= '0;
      b_ptr            <= '0;
      inflight         <= '0;
      issue            <= 1'b0;
      first            <= 1'b0;
      last             <= 1'b0;
      a_addr           <= '0;
      b_addr           <= '0;
      compute_finished <= 1'b0;
      busy             <= 1'b0;
    end else begin
      issue            <= 1'b0;
      first            <= 1'b0;
      last             <= 1'b0;
      compute_finished <= 1'b0;
      inflight <= inflight + CW'(issue_now && idx == '0) - CW'(fifo_wr_en);
      unique case (state)
        IDLE: begin
          row    <= '0;
          col    <= '0;
          idx    <= '0;
          a_base <= '0;
          a_ptr  <= '0;
          b_ptr  <= '0;
          if (job_start) begin
            k_q   <= k_in;
            busy  <= 1'b1;
            state <= (k_in == '0) ? DONE : RUN;
          end
        end
        RUN, HOLD: begin
          if (issue_now) begin
            state  <= RUN;
            issue  <= 1'b1;
            first  <= idx == '0;
            last   <= last_idx;
            a_addr <= a_ptr;
            b_addr <= b_ptr;
            if (last_idx) begin
              idx <= '0;
              if (last_col) begin
                col    <= '0;
                row    <= row + 1'b1;
                b_ptr  <= '0;
                a_base <= a_base + AW'(k_q);
                a_ptr  <= a_base + AW'(k_q);
                if (last_row) state <= DRAIN;
              end else begin
                col   <= col + 1'b1;
                b_ptr <= BW'(col) + BW'(1);
                a_ptr <= a_base;
              end
            end else begin
              idx   <= idx + 1'b1;
              a_ptr <= a_ptr + 1'b1;
              b_ptr <= b_ptr + BW'(N);
            end
          end else begin
            state <= HOLD;
          end
        end
        DRAIN: if (inflight == '0 && !vld_occ && !wr_occ) state <= DONE;
        DONE: begin
          compute_finished <= 1'b1;
          busy             <= 1'b0;
          a_addr           <= '0;
          b_addr           <= '0;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes follow the address by the memory latency so they line up with read data.
  mmm_delay_line #(.W(2), .DEPTH(RD_LAT)) u_vld (
    .clk      (clk),
    .reset    (reset),
    .din      ({issue, first}),
    .dout     (vld_out),
    .occupied (vld_occ)
  );

  assign valid_input = vld_out[1];
  assign clear_acc   = vld_out[0];

  mmm_delay_line #(.W(1), .DEPTH(RD_LAT + MAC_LAT)) u_wr (
    .clk      (clk),
    .reset    (reset),
    .din      (last),
    .dout     (fifo_wr_en),
    .occupied (wr_occ)
  );

`ifdef MMM_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (reset || job_start) begin
      stall_cycles <= '0;
      job_cycles   <= '0;
    end else begin
      if ((state == RUN || state == HOLD || state == DRAIN) && job_cycles != '1)
        job_cycles <= job_cycles + 32'd1;
      if (state == HOLD && stall_cycles != '1)
        stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mmm_sequencer.sv
// Directed bench for mmm_sequencer at M=2, N=3, RD_LAT=MAC_LAT=1; covers MMM_SEQ_PERF_EN when defined.
module tb_mmm_sequencer;

  logic       clk, reset, matrices_loaded;
  logic [3:0] K;
  logic [3:0] a_addr;
  logic [4:0] b_addr;
  logic       valid_input, clear_acc, fifo_wr_en, compute_finished, busy;
  logic [3:0] fifo_capacity;
`ifdef MMM_SEQ_PERF_EN
  logic [31:0] stall_cycles, job_cycles;
`endif

  mmm_sequencer #(.M(2), .N(3), .MAXK(8), .RD_LAT(1), .MAC_LAT(1), .FIFO_DEPTH(9)) dut (
    .clk              (clk),
    .reset            (reset),
    .matrices_loaded  (matrices_loaded),
    .K                (K),
    .a_addr           (a_addr),
    .b_addr           (b_addr),
    .valid_input      (valid_input),
    .clear_acc        (clear_acc),
    .fifo_wr_en       (fifo_wr_en),
    .fifo_capacity    (fifo_capacity),
    .compute_finished (compute_finished),
    .busy             (busy)
`ifdef MMM_SEQ_PERF_EN
    ,
    .stall_cycles     (stall_cycles),
    .job_cycles       (job_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks, errors, cyc, pend;
  bit consume;
  int a_log[$], b_log[$], c_log[$], wr_log[$], cf_log[$];
  logic [3:0] pa;
  logic [4:0] pb;

  task automatic clear_logs();
    a_log.delete(); b_log.delete(); c_log.delete(); wr_log.delete(); cf_log.delete();
    cyc = 0;
  endtask

  // One clock; samples 1 time unit after the edge. Address is logged one cycle
  // before its valid_input because read latency is 1.
  task automatic step();
    @(posedge clk); #1;
    cyc++;
    if (pend != 0 && consume) fifo_capacity = fifo_capacity - 4'd1;
    pend = int'(fifo_wr_en);
    if (valid_input) begin
      a_log.push_back(int'(pa)); b_log.push_back(int'(pb)); c_log.push_back(int'(clear_acc));
    end
    if (fifo_wr_en) wr_log.push_back(cyc);
    if (compute_finished) cf_log.push_back(cyc);
    pa = a_addr; pb = b_addr;
  endtask

  task automatic wait_done(input int budget);
    while (cf_log.size() == 0 && cyc < budget) step();
  endtask

  task automatic do_reset();
    reset = 1'b1; matrices_loaded = 1'b0; consume = 1'b0; pend = 0;
    step(); step();
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic test_reset();
    reset = 1'b1; matrices_loaded = 1'b0;
    step(); step();
    checks++; if (a_addr !== 4'd0) begin errors++; $display("FAIL rst_a_addr got %0d want 0", a_addr); end
    checks++; if (b_addr !== 5'd0) begin errors++; $display("FAIL rst_b_addr got %0d want 0", b_addr); end
    checks++; if ({valid_input, clear_acc, fifo_wr_en} !== 3'b000) begin errors++; $display("FAIL rst_strobes got %b want 000", {valid_input, clear_acc, fifo_wr_en}); end
    checks++; if ({compute_finished, busy} !== 2'b00) begin errors++; $display("FAIL rst_cf_busy got %b want 00", {compute_finished, busy}); end
  endtask

  task automatic test_k2();
    int exp_a[12], exp_b[12], av, bv, cv;
    exp_a = '{0, 1, 0, 1, 0, 1, 2, 3, 2, 3, 2, 3};
    exp_b = '{0, 3, 1, 4, 2, 5, 0, 3, 1, 4, 2, 5};
    do_reset();
    fifo_capacity = 4'd9; K = 4'd2; matrices_loaded = 1'b1;
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL k2_busy got %b want 1", busy); end
    wait_done(60);
    matrices_loaded = 1'b0;
    checks++; if (a_log.size() != 12) begin errors++; $display("FAIL k2_nvalid got %0d want 12", a_log.size()); end
    for (int i = 0; i < 12; i++) begin
      av = (i < a_log.size()) ? a_log[i] : -1;
      bv = (i < b_log.size()) ? b_log[i] : -1;
      cv = (i < c_log.size()) ? c_log[i] : -1;
      checks++; if (av != exp_a[i]) begin errors++; $display("FAIL k2_a[%0d] got %0d want %0d", i, av, exp_a[i]); end
      checks++; if (bv != exp_b[i]) begin errors++; $display("FAIL k2_b[%0d] got %0d want %0d", i, bv, exp_b[i]); end
      checks++; if (cv != int'(i % 2 == 0)) begin errors++; $display("FAIL k2_clr[%0d] got %0d want %0d", i, cv, int'(i % 2 == 0)); end
    end
    checks++; if (wr_log.size() != 6) begin errors++; $display("FAIL k2_nwr got %0d want 6", wr_log.size()); end
    for (int i = 0; i < 6; i++) begin
      av = (i < wr_log.size()) ? wr_log[i] : -1;
      checks++; if (av != 5 + 2 * i) begin errors++; $display("FAIL k2_wr_cyc[%0d] got %0d want %0d", i, av, 5 + 2 * i); end
    end
    av = (cf_log.size() > 0) ? cf_log[0] : -1;
    checks++; if (cf_log.size() != 1 || av != 18) begin errors++; $display("FAIL k2_cf got n=%0d cyc=%0d want n=1 cyc=18", cf_log.size(), av); end
    checks++; if (busy !== 1'b0 || a_addr !== 4'd0) begin errors++; $display("FAIL k2_idle got busy=%b a=%0d want 0 0", busy, a_addr); end
`ifdef MMM_SEQ_PERF_EN
    checks++; if (job_cycles !== 32'd16) begin errors++; $display("FAIL k2_job got %0d want 16", job_cycles); end
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL k2_stall got %0d want 0", stall_cycles); end
`endif
  endtask

  task automatic test_k1();
    int exp_a[6], exp_b[6], av, bv, cv;
    exp_a = '{0, 0, 0, 1, 1, 1};
    exp_b = '{0, 1, 2, 0, 1, 2};
    do_reset();
    fifo_capacity = 4'd9; K = 4'd1; matrices_loaded = 1'b1;
    wait_done(40);
    matrices_loaded = 1'b0;
    for (int i = 0; i < 6; i++) begin
      av = (i < a_log.size()) ? a_log[i] : -1;
      bv = (i < b_log.size()) ? b_log[i] : -1;
      cv = (i < c_log.size()) ? c_log[i] : -1;
      checks++; if (av != exp_a[i] || bv != exp_b[i]) begin errors++; $display("FAIL k1_addr[%0d] got a=%0d b=%0d want a=%0d b=%0d", i, av, bv, exp_a[i], exp_b[i]); end
      checks++; if (cv != 1) begin errors++; $display("FAIL k1_clr[%0d] got %0d want 1", i, cv); end
      av = (i < wr_log.size()) ? wr_log[i] : -1;
      checks++; if (av != 4 + i) begin errors++; $display("FAIL k1_wr_cyc[%0d] got %0d want %0d", i, av, 4 + i); end
    end
    av = (cf_log.size() > 0) ? cf_log[0] : -1;
    checks++; if (a_log.size() != 6 || wr_log.size() != 6 || av != 12) begin errors++; $display("FAIL k1_counts got nv=%0d nwr=%0d cf=%0d want 6 6 12", a_log.size(), wr_log.size(), av); end
  endtask

  task automatic test_backpressure();
    int exp_a[3], exp_b[3], av, bv;
    exp_a = '{0, 1, 2};
    exp_b = '{2, 5, 8};
    do_reset();
    consume = 1'b1; fifo_capacity = 4'd2; K = 4'd3; matrices_loaded = 1'b1;
    for (int i = 0; i < 30; i++) step();
    checks++; if (wr_log.size() != 2) begin errors++; $display("FAIL bp_held_nwr got %0d want 2", wr_log.size()); end
    checks++; if (a_log.size() != 6) begin errors++; $display("FAIL bp_held_nvalid got %0d want 6", a_log.size()); end
    checks++; if (busy !== 1'b1 || valid_input !== 1'b0) begin errors++; $display("FAIL bp_held_state got busy=%b vi=%b want 1 0", busy, valid_input); end
    av = (wr_log.size() > 1) ? wr_log[1] : -1;
    checks++; if (wr_log.size() < 1 || wr_log[0] != 6 || av != 9) begin errors++; $display("FAIL bp_wr_cyc got %0d,%0d want 6,9", (wr_log.size() > 0) ? wr_log[0] : -1, av); end
`ifdef MMM_SEQ_PERF_EN
    checks++; if (stall_cycles !== 32'd22) begin errors++; $display("FAIL bp_stall_mid got %0d want 22", stall_cycles); end
`endif
    fifo_capacity = 4'd9;
    wait_done(80);
    matrices_loaded = 1'b0;
    checks++; if (wr_log.size() != 6 || a_log.size() != 18) begin errors++; $display("FAIL bp_total got nwr=%0d nv=%0d want 6 18", wr_log.size(), a_log.size()); end
    for (int i = 0; i < 3; i++) begin
      av = (6 + i < a_log.size()) ? a_log[6 + i] : -1;
      bv = (6 + i < b_log.size()) ? b_log[6 + i] : -1;
      checks++; if (av != exp_a[i] || bv != exp_b[i]) begin errors++; $display("FAIL bp_resume[%0d] got a=%0d b=%0d want a=%0d b=%0d", i, av, bv, exp_a[i], exp_b[i]); end
    end
    av = (cf_log.size() > 0) ? cf_log[0] : -1;
    checks++; if (av != 47) begin errors++; $display("FAIL bp_cf got %0d want 47", av); end
`ifdef MMM_SEQ_PERF_EN
    checks++; if (stall_cycles !== 32'd23 || job_cycles !== 32'd45) begin errors++; $display("FAIL bp_perf got stall=%0d job=%0d want 23 45", stall_cycles, job_cycles); end
`endif
  endtask

  task automatic test_k0();
    int av;
    do_reset();
    fifo_capacity = 4'd9; K = 4'd0; matrices_loaded = 1'b1;
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL k0_busy got %b want 1", busy); end
    step();
    matrices_loaded = 1'b0;
    step(); step(); step();
    av = (cf_log.size() > 0) ? cf_log[0] : -1;
    checks++; if (cf_log.size() != 1 || av != 2) begin errors++; $display("FAIL k0_cf got n=%0d cyc=%0d want n=1 cyc=2", cf_log.size(), av); end
    checks++; if (a_log.size() != 0 || wr_log.size() != 0) begin errors++; $display("FAIL k0_activity got nv=%0d nwr=%0d want 0 0", a_log.size(), wr_log.size()); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    fifo_capacity = 4'd9; K = 4'd3; matrices_loaded = 1'b1;
    step(); step(); step();
    checks++; if (a_addr !== 4'd1 || valid_input !== 1'b1) begin errors++; $display("FAIL mr_pre got a=%0d vi=%b want 1 1", a_addr, valid_input); end
    reset = 1'b1;
    step();
    checks++; if ({a_addr, b_addr} !== 9'd0) begin errors++; $display("FAIL mr_addr got a=%0d b=%0d want 0 0", a_addr, b_addr); end
    checks++; if ({valid_input, clear_acc, fifo_wr_en, compute_finished, busy} !== 5'd0) begin errors++; $display("FAIL mr_out got %b want 00000", {valid_input, clear_acc, fifo_wr_en, compute_finished, busy}); end
    reset = 1'b0; matrices_loaded = 1'b0;
    clear_logs();
    for (int i = 0; i < 10; i++) step();
    checks++; if (wr_log.size() != 0 || a_log.size() != 0 || busy !== 1'b0) begin errors++; $display("FAIL mr_after got nwr=%0d nv=%0d busy=%b want 0 0 0", wr_log.size(), a_log.size(), busy); end
`ifdef MMM_SEQ_PERF_EN
    checks++; if (job_cycles !== 32'd0) begin errors++; $display("FAIL mr_job got %0d want 0", job_cycles); end
`endif
  endtask

  task automatic test_back_to_back();
    int exp_a[12], av;
    exp_a = '{0, 1, 0, 1, 0, 1, 2, 3, 2, 3, 2, 3};
    do_reset();
    fifo_capacity = 4'd9; K = 4'd3; matrices_loaded = 1'b1;
    wait_done(60);
    av = (cf_log.size() > 0) ? cf_log[0] : -1;
    checks++; if (av != 24 || wr_log.size() != 6) begin errors++; $display("FAIL b2b_job1 got cf=%0d nwr=%0d want 24 6", av, wr_log.size()); end
`ifdef MMM_SEQ_PERF_EN
    checks++; if (job_cycles !== 32'd22 || stall_cycles !== 32'd0) begin errors++; $display("FAIL b2b_perf1 got job=%0d stall=%0d want 22 0", job_cycles, stall_cycles); end
`endif
    K = 4'd2;
    clear_logs();
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_ignore got busy=%b want 0", busy); end
    clear_logs();
    wait_done(60);
    matrices_loaded = 1'b0;
    for (int i = 0; i < 12; i++) begin
      av = (i < a_log.size()) ? a_log[i] : -1;
      checks++; if (av != exp_a[i]) begin errors++; $display("FAIL b2b_a[%0d] got %0d want %0d", i, av, exp_a[i]); end
    end
    av = (cf_log.size() > 0) ? cf_log[0] : -1;
    checks++; if (av != 18 || wr_log.size() != 6) begin errors++; $display("FAIL b2b_job2 got cf=%0d nwr=%0d want 18 6", av, wr_log.size()); end
`ifdef MMM_SEQ_PERF_EN
    checks++; if (job_cycles !== 32'd16 || stall_cycles !== 32'd0) begin errors++; $display("FAIL b2b_perf2 got job=%0d stall=%0d want 16 0", job_cycles, stall_cycles); end
`endif
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; pend = 0; consume = 1'b0;
    reset = 1'b1; matrices_loaded = 1'b0; K = 4'd0; fifo_capacity = 4'd9;
    pa = '0; pb = '0;
    test_reset();
    test_k2();
    test_k1();
    test_backpressure();
    test_k0();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
